// File: rtl/ssp_rx_deser.sv
// Serial-to-parallel receiver: a frame pulse starts each word, bits arrive MSB first, and completed words go to an output store.
// Define SSP_RX_BUF2_EN to make the output store a 2-entry FIFO; without it the store is a single holding register.
module ssp_rx_deser (
  input  logic       i_clk,
  input  logic       i_sync_reset_bar,
  input  logic       i_rx_data,
  input  logic       i_rx_frame,
  input  logic       i_rx_ready,
  input  logic       i_overrun_clr,
  output logic [7:0] o_rx_word,
  output logic       o_rx_valid,
  output logic       o_rx_overrun,
  output logic       o_rx_busy
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [7:0]  head_q, head_d;
  logic        ovr_q, ovr_d;
  logic        word_done;
  logic [7:0]  new_word;
  logic        pop;
  logic        drop;
`ifdef SSP_RX_BUF2_EN
  logic [7:0]  tail_q, tail_d;
  logic [1:0]  fill_q, fill_d;
`else
  logic        valid_q, valid_d;
`endif

  // Receive FSM and shift register
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    word_done = 1'b0;
    new_word  = {shreg_q[6:0], i_rx_data};
    case (state_q)
      IDLE: begin
        if (i_rx_frame) begin
          state_d = SHIFT;
          cnt_d   = 3'd0;
          shreg_d = 8'h00;
        end
      end
      SHIFT: begin
        if (cnt_q == 3'd7) begin
          // Last bit lands here; a frame on this same edge chains straight into the next word.
          word_done = 1'b1;
          cnt_d     = 3'd0;
          shreg_d   = 8'h00;
          state_d   = i_rx_frame ? SHIFT : IDLE;
        end else if (i_rx_frame) begin
          cnt_d   = 3'd0;
          shreg_d = 8'h00;
        end else begin
          cnt_d   = cnt_q + 3'd1;
          shreg_d = new_word;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pop = o_rx_valid & i_rx_ready;

  // Output store
`ifdef SSP_RX_BUF2_EN
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    fill_d = fill_q;
    drop   = 1'b0;
    case ({pop, word_done})
      2'b01: begin
        if (fill_q == 2'd0) begin
          head_d = new_word;
          fill_d = 2'd1;
        end else if (fill_q == 2'd1) begin
          tail_d = new_word;
          fill_d = 2'd2;
        end else begin
          drop = 1'b1;
        end
      end
      2'b10: begin
        if (fill_q == 2'd2) begin
          head_d = tail_q;
          fill_d = 2'd1;
        end else begin
          fill_d = 2'd0;
        end
      end
      2'b11: begin
        if (fill_q == 2'd2) begin
          head_d = tail_q;
          tail_d = new_word;
        end else begin
          head_d = new_word;
        end
      end
      default: ;
    endcase
  end

  assign o_rx_valid = (fill_q != 2'd0);
`else
  always_comb begin
    head_d  = head_q;
    valid_d = valid_q;
    drop    = 1'b0;
    case ({pop, word_done})
      2'b01: begin
        if (!valid_q) begin
          head_d  = new_word;
          valid_d = 1'b1;
        end else begin
          drop = 1'b1;
        end
      end
      2'b10: valid_d = 1'b0;
      2'b11: head_d = new_word;
      default: ;
    endcase
  end

  assign o_rx_valid = valid_q;
`endif

  // A drop on the same edge as a clear leaves the flag set.
  always_comb begin
    ovr_d = ovr_q;
    if (drop)
      ovr_d = 1'b1;
    else if (i_overrun_clr)
      ovr_d = 1'b0;
  end

  always_ff @(negedge i_clk) begin
    if (!i_sync_reset_bar) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      shreg_q <= 8'h00;
      head_q  <= 8'h00;
      ovr_q   <= 1'b0;
`ifdef SSP_RX_BUF2_EN
      tail_q  <= 8'h00;
      fill_q  <= 2'd0;
`else
      valid_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      head_q  <= head_d;
      ovr_q   <= ovr_d;
`ifdef SSP_RX_BUF2_EN
      tail_q  <= tail_d;
      fill_q  <= fill_d;
`else
      valid_q <= valid_d;
`endif
    end
  end

  assign o_rx_word    = head_q;
  assign o_rx_overrun = ovr_q;
  assign o_rx_busy    = (state_q == SHIFT);

endmodule
